// File: rtl/tetris_input_pkg.sv
// Shared types for the Tetris input scheduler: command encoding, scan codes,
// repeat-timer states and the fixed arbitration order.
package tetris_input_pkg;

   typedef enum logic [2:0] {
      CMD_NONE   = 3'd0,
      CMD_LEFT   = 3'd1,
      CMD_RIGHT  = 3'd2,
      CMD_DOWN   = 3'd3,
      CMD_ROTATE = 3'd4,
      CMD_DROP   = 3'd5
   } cmd_e;

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_DELAY,
      RPT_REPEAT
   } rpt_state_e;

   // Bit positions in key_held / pending vectors; bit i carries command i+1.
   localparam int NUM_KEYS = 5;
   localparam int K_LEFT   = 0;
   localparam int K_RIGHT  = 1;
   localparam int K_DOWN   = 2;
   localparam int K_ROTATE = 3;
   localparam int K_DROP   = 4;

   localparam logic [7:0] KEY_LEFT   = 8'h6B;
   localparam logic [7:0] KEY_RIGHT  = 8'h74;
   localparam logic [7:0] KEY_DOWN   = 8'h72;
   localparam logic [7:0] KEY_ROTATE = 8'h75;
   localparam logic [7:0] KEY_DROP   = 8'h29;
   localparam logic [7:0] KEY_ESC    = 8'h76;

   localparam logic [7:0] KEY_CODES [NUM_KEYS] =
      '{KEY_LEFT, KEY_RIGHT, KEY_DOWN, KEY_ROTATE, KEY_DROP};

   // Highest priority first.
   localparam int PRIO_ORDER [NUM_KEYS] = '{K_DROP, K_ROTATE, K_LEFT, K_RIGHT, K_DOWN};

   function automatic cmd_e pick_cmd(input logic [NUM_KEYS-1:0] pend);
      cmd_e c;
      c = CMD_NONE;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (pend[PRIO_ORDER[i]]) c = cmd_e'(3'(PRIO_ORDER[i] + 1));
      end
      return c;
   endfunction

   function automatic logic [NUM_KEYS-1:0] cmd_mask(input cmd_e c);
      logic [NUM_KEYS-1:0] m;
      for (int i = 0; i < NUM_KEYS; i++) m[i] = (c == cmd_e'(3'(i + 1)));
      return m;
   endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Per-key DAS/ARR auto-repeat: fires on the initial press, then after
// DAS_TICKS ticks, then every ARR_TICKS ticks until released or cleared.
module key_repeat_timer
   import tetris_input_pkg::*;
#(
   parameter int DAS_TICKS = 170,
   parameter int ARR_TICKS = 50
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_press,
   input  logic key_release,
   input  logic tick,
   input  logic clear,
   output logic fire
);

   localparam int MAX_TICKS = (DAS_TICKS > ARR_TICKS) ? DAS_TICKS : ARR_TICKS;
   localparam int CW        = $clog2(MAX_TICKS + 1);

   rpt_state_e    state_reg;
   logic [CW-1:0] cnt_reg;
   logic          expire;

   assign expire = tick && (state_reg != RPT_IDLE) && (cnt_reg == CW'(1));

   // A key event in the same cycle as a tick takes precedence; the tick is lost.
   always_comb begin
      fire = 1'b0;
      if (!clear && !key_release) begin
         if (key_press) fire = (state_reg == RPT_IDLE);
         else           fire = expire;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= RPT_IDLE;
         cnt_reg   <= '0;
      end else if (clear || key_release) begin
         state_reg <= RPT_IDLE;
      end else if (key_press) begin
         if (state_reg == RPT_IDLE) begin
            state_reg <= RPT_DELAY;
            cnt_reg   <= CW'(DAS_TICKS);
         end
      end else if (expire) begin
         state_reg <= RPT_REPEAT;
         cnt_reg   <= CW'(ARR_TICKS);
      end else if (tick && (state_reg != RPT_IDLE)) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

endmodule

// File: rtl/tetris_input_scheduler.sv
// PS/2 key events -> arbitrated Tetris commands over valid/ready.
// Optional pause on Esc is enabled by defining TETRIS_INPUT_PAUSE_EN.
module tetris_input_scheduler
   import tetris_input_pkg::*;
#(
   parameter int CLK_HZ    = 50000000,
   parameter int TICK_HZ   = 1000,
   parameter int DAS_TICKS = 170,
   parameter int ARR_TICKS = 50
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       valid,
   input  logic       makeBreak,
   input  logic [7:0] outCode,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [2:0] cmd,
   output logic [4:0] key_held,
   output logic       paused
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0]       presc_reg;
   logic                tick;
   logic [NUM_KEYS-1:0] key_hit, key_make, key_break;
   logic [NUM_KEYS-1:0] key_held_reg, pend_reg, pend_next, pend_set, lock_clr, load_mask;
   logic                paused_reg, pause_enter, load;
   logic                cmd_valid_reg;
   cmd_e                cmd_reg, next_cmd;

   // With DIV == 1 the counter sits at 0 and tick is permanently high.
   assign tick = (presc_reg == PW'(DIV - 1));

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n)  presc_reg <= '0;
      else if (tick) presc_reg <= '0;
      else           presc_reg <= presc_reg + 1'b1;
   end

`ifdef TETRIS_INPUT_PAUSE_EN
   logic esc_hit, esc_held_reg;

   assign esc_hit     = valid && (outCode == KEY_ESC);
   assign pause_enter = esc_hit && makeBreak && !esc_held_reg && !paused_reg;

   // Typematic resends of Esc must not re-toggle, so Esc gets its own held flag.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         esc_held_reg <= 1'b0;
         paused_reg   <= 1'b0;
      end else if (esc_hit) begin
         esc_held_reg <= makeBreak;
         if (makeBreak && !esc_held_reg) paused_reg <= ~paused_reg;
      end
   end
`else
   assign paused_reg  = 1'b0;
   assign pause_enter = 1'b0;
`endif

   assign key_make  = key_hit & {NUM_KEYS{makeBreak & ~paused_reg}};
   assign key_break = key_hit & {NUM_KEYS{~makeBreak}};

   // A make on one direction cancels the opposite direction's repeat and pending.
   assign lock_clr = {3'b000, key_make[K_LEFT], key_make[K_RIGHT]};

   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      assign key_hit[gi] = valid && (outCode == KEY_CODES[gi]);
      if (gi <= K_DOWN) begin : g_rpt
         key_repeat_timer #(
            .DAS_TICKS(DAS_TICKS),
            .ARR_TICKS(ARR_TICKS)
         ) u_rpt (
            .clk        (CLOCK_50),
            .reset_n    (reset_n),
            .key_press  (key_make[gi]),
            .key_release(key_break[gi]),
            .tick       (tick),
            .clear      (lock_clr[gi] | pause_enter),
            .fire       (pend_set[gi])
         );
      end else begin : g_edge
         assign pend_set[gi] = key_make[gi] & ~key_held_reg[gi];
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) key_held_reg <= '0;
      else          key_held_reg <= (key_held_reg | key_make) & ~key_break;
   end

   assign next_cmd  = pick_cmd(pend_reg);
   assign load      = (!cmd_valid_reg || cmd_ready) && !pause_enter;
   assign load_mask = load ? cmd_mask(next_cmd) : '0;

   // New sets are OR'd in last so a set colliding with an accept survives.
   always_comb begin
      pend_next = (pend_reg & ~load_mask & ~lock_clr) | pend_set;
      if (pause_enter) pend_next = '0;
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         pend_reg      <= '0;
         cmd_valid_reg <= 1'b0;
         cmd_reg       <= CMD_NONE;
      end else begin
         pend_reg <= pend_next;
         if (load) begin
            cmd_reg       <= next_cmd;
            cmd_valid_reg <= |pend_reg;
         end else if (cmd_valid_reg && cmd_ready) begin
            cmd_reg       <= CMD_NONE;
            cmd_valid_reg <= 1'b0;
         end
      end
   end

   assign cmd_valid = cmd_valid_reg;
   assign cmd       = cmd_reg;
   assign key_held  = key_held_reg;
   assign paused    = paused_reg;

endmodule

// File: tb/tb_tetris_input_scheduler.sv
// Directed bench for tetris_input_scheduler with a tick every cycle, DAS=5, ARR=2.
module tb_tetris_input_scheduler;
   import tetris_input_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       valid = 1'b0;
   logic       makeBreak = 1'b0;
   logic [7:0] outCode = 8'h00;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic [4:0] key_held;
   logic       paused;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   logic [2:0] log_cmd[$];
   int         log_cyc[$];

   tetris_input_scheduler #(
      .CLK_HZ   (1000),
      .TICK_HZ  (1000),
      .DAS_TICKS(5),
      .ARR_TICKS(2)
   ) dut (
      .CLOCK_50 (clk),
      .reset_n  (reset_n),
      .valid    (valid),
      .makeBreak(makeBreak),
      .outCode  (outCode),
      .cmd_ready(cmd_ready),
      .cmd_valid(cmd_valid),
      .cmd      (cmd),
      .key_held (key_held),
      .paused   (paused)
   );

   always #5 clk = ~clk;

   // Handshake log: one line per accepted command, tagged with its edge index.
   always @(posedge clk) begin
      if (reset_n && cmd_valid && cmd_ready) begin
         log_cmd.push_back(cmd);
         log_cyc.push_back(cyc);
         $display("cyc %0d: accepted cmd %0d", cyc, cmd);
      end
      cyc++;
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic key(input logic [7:0] code, input logic mb);
      valid = 1'b1; outCode = code; makeBreak = mb;
      step();
      valid = 1'b0; outCode = 8'h00; makeBreak = 1'b0;
   endtask

   task automatic clear_log();
      log_cmd.delete();
      log_cyc.delete();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; cmd_ready = 1'b0;
      step(2);
      n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
      n_cmp++; if (cmd !== 3'd0) begin n_bad++; $display("FAIL reset_cmd: got %0d want 0", cmd); end
      n_cmp++; if (key_held !== 5'b0) begin n_bad++; $display("FAIL reset_key_held: got %b want 00000", key_held); end
      n_cmp++; if (paused !== 1'b0) begin n_bad++; $display("FAIL reset_paused: got %b want 0", paused); end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_tap_left();
      int s;
      cmd_ready = 1'b1; clear_log(); s = cyc;
      key(KEY_LEFT, 1'b1);
      n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL tap_early_valid: got %b want 0", cmd_valid); end
      key(KEY_LEFT, 1'b0);
      n_cmp++; if ({cmd_valid, cmd} !== {1'b1, 3'd1}) begin n_bad++; $display("FAIL tap_latency: got valid=%b cmd=%0d want valid=1 cmd=1", cmd_valid, cmd); end
      n_cmp++; if (key_held !== 5'b00000) begin n_bad++; $display("FAIL tap_held: got %b want 00000", key_held); end
      step(10);
      n_cmp++; if (log_cmd.size() != 1) begin n_bad++; $display("FAIL tap_count: got %0d want 1", log_cmd.size()); end
      n_cmp++; if (((log_cmd.size() > 0) ? log_cmd[0] : 3'd7) !== 3'd1) begin n_bad++; $display("FAIL tap_cmd: got %0d want 1", (log_cmd.size() > 0) ? log_cmd[0] : 3'd7); end
      n_cmp++; if (((log_cyc.size() > 0) ? log_cyc[0] : -1) != s + 2) begin n_bad++; $display("FAIL tap_cycle: got %0d want %0d", (log_cyc.size() > 0) ? log_cyc[0] : -1, s + 2); end
   endtask

   task automatic test_hold_right();
      int s;
      int exp_off[4] = '{2, 7, 9, 11};
      cmd_ready = 1'b1; clear_log(); s = cyc;
      key(KEY_RIGHT, 1'b1);
      n_cmp++; if (key_held !== 5'b00010) begin n_bad++; $display("FAIL hold_held: got %b want 00010", key_held); end
      step(10);
      key(KEY_RIGHT, 1'b0);
      step(8);
      n_cmp++; if (log_cmd.size() != 4) begin n_bad++; $display("FAIL hold_count: got %0d want 4", log_cmd.size()); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (((i < log_cmd.size()) ? log_cmd[i] : 3'd7) !== 3'd2 || ((i < log_cyc.size()) ? log_cyc[i] : -1) != s + exp_off[i]) begin
            n_bad++;
            $display("FAIL hold_cmd%0d: got cmd=%0d cyc=%0d want cmd=2 cyc=%0d", i,
                     (i < log_cmd.size()) ? log_cmd[i] : 3'd7, (i < log_cyc.size()) ? log_cyc[i] : -1, s + exp_off[i]);
         end
      end
   endtask

   task automatic test_priority_stall();
      int r;
      cmd_ready = 1'b0; clear_log();
      key(KEY_DROP, 1'b1);
      key(KEY_ROTATE, 1'b1);
      n_cmp++; if (key_held !== 5'b11000) begin n_bad++; $display("FAIL prio_held: got %b want 11000", key_held); end
      for (int i = 0; i < 10; i++) begin
         n_cmp++; if ({cmd_valid, cmd} !== {1'b1, 3'd5}) begin n_bad++; $display("FAIL prio_stall%0d: got valid=%b cmd=%0d want valid=1 cmd=5", i, cmd_valid, cmd); end
         step();
      end
      cmd_ready = 1'b1; r = cyc;
      step(4);
      n_cmp++; if (log_cmd.size() != 2) begin n_bad++; $display("FAIL prio_count: got %0d want 2", log_cmd.size()); end
      n_cmp++; if (((log_cmd.size() > 0) ? log_cmd[0] : 3'd7) !== 3'd5 || ((log_cyc.size() > 0) ? log_cyc[0] : -1) != r) begin n_bad++; $display("FAIL prio_first: got cmd=%0d cyc=%0d want cmd=5 cyc=%0d", (log_cmd.size() > 0) ? log_cmd[0] : 3'd7, (log_cyc.size() > 0) ? log_cyc[0] : -1, r); end
      n_cmp++; if (((log_cmd.size() > 1) ? log_cmd[1] : 3'd7) !== 3'd4 || ((log_cyc.size() > 1) ? log_cyc[1] : -1) != r + 1) begin n_bad++; $display("FAIL prio_back_to_back: got cmd=%0d cyc=%0d want cmd=4 cyc=%0d", (log_cmd.size() > 1) ? log_cmd[1] : 3'd7, (log_cyc.size() > 1) ? log_cyc[1] : -1, r + 1); end
      key(KEY_DROP, 1'b0);
      key(KEY_ROTATE, 1'b0);
      n_cmp++; if (key_held !== 5'b00000) begin n_bad++; $display("FAIL prio_release: got %b want 00000", key_held); end
   endtask

   task automatic test_lockout();
      int s;
      cmd_ready = 1'b1; clear_log(); s = cyc;
      key(KEY_LEFT, 1'b1);
      step(2);
      key(KEY_RIGHT, 1'b1);
      n_cmp++; if (key_held !== 5'b00011) begin n_bad++; $display("FAIL lock_held: got %b want 00011", key_held); end
      key(KEY_RIGHT, 1'b0);
      step(12);
      n_cmp++; if (log_cmd.size() != 2) begin n_bad++; $display("FAIL lock_count: got %0d want 2", log_cmd.size()); end
      n_cmp++; if (((log_cmd.size() > 0) ? log_cmd[0] : 3'd7) !== 3'd1 || ((log_cyc.size() > 0) ? log_cyc[0] : -1) != s + 2) begin n_bad++; $display("FAIL lock_left: got cmd=%0d cyc=%0d want cmd=1 cyc=%0d", (log_cmd.size() > 0) ? log_cmd[0] : 3'd7, (log_cyc.size() > 0) ? log_cyc[0] : -1, s + 2); end
      n_cmp++; if (((log_cmd.size() > 1) ? log_cmd[1] : 3'd7) !== 3'd2 || ((log_cyc.size() > 1) ? log_cyc[1] : -1) != s + 5) begin n_bad++; $display("FAIL lock_right: got cmd=%0d cyc=%0d want cmd=2 cyc=%0d", (log_cmd.size() > 1) ? log_cmd[1] : 3'd7, (log_cyc.size() > 1) ? log_cyc[1] : -1, s + 5); end
      key(KEY_LEFT, 1'b0);
   endtask

   task automatic test_typematic();
      int s;
      cmd_ready = 1'b1; clear_log(); s = cyc;
      key(KEY_ROTATE, 1'b1);
      step();
      key(KEY_ROTATE, 1'b1);
      step();
      key(KEY_ROTATE, 1'b1);
      key(KEY_ROTATE, 1'b0);
      step();
      key(KEY_ROTATE, 1'b1);
      key(KEY_ROTATE, 1'b0);
      step(5);
      n_cmp++; if (log_cmd.size() != 2) begin n_bad++; $display("FAIL type_count: got %0d want 2", log_cmd.size()); end
      n_cmp++; if (((log_cyc.size() > 0) ? log_cyc[0] : -1) != s + 2) begin n_bad++; $display("FAIL type_first: got cyc=%0d want %0d", (log_cyc.size() > 0) ? log_cyc[0] : -1, s + 2); end
      n_cmp++; if (((log_cmd.size() > 1) ? log_cmd[1] : 3'd7) !== 3'd4 || ((log_cyc.size() > 1) ? log_cyc[1] : -1) != s + 9) begin n_bad++; $display("FAIL type_second: got cmd=%0d cyc=%0d want cmd=4 cyc=%0d", (log_cmd.size() > 1) ? log_cmd[1] : 3'd7, (log_cyc.size() > 1) ? log_cyc[1] : -1, s + 9); end
   endtask

   task automatic test_reset_mid_repeat();
      int s;
      cmd_ready = 1'b0; clear_log();
      key(KEY_DOWN, 1'b1);
      step(7);
      n_cmp++; if ({cmd_valid, cmd} !== {1'b1, 3'd3}) begin n_bad++; $display("FAIL rst_setup: got valid=%b cmd=%0d want valid=1 cmd=3", cmd_valid, cmd); end
      reset_n = 1'b0;
      step();
      n_cmp++; if ({cmd_valid, cmd, key_held, paused} !== 10'b0) begin n_bad++; $display("FAIL rst_mid_outputs: got valid=%b cmd=%0d held=%b paused=%b want all 0", cmd_valid, cmd, key_held, paused); end
      reset_n = 1'b1; cmd_ready = 1'b1; clear_log();
      step(10);
      n_cmp++; if (log_cmd.size() != 0) begin n_bad++; $display("FAIL rst_quiet: got %0d cmds want 0", log_cmd.size()); end
      s = cyc;
      key(KEY_DOWN, 1'b1);
      key(KEY_DOWN, 1'b0);
      step(4);
      n_cmp++; if (log_cmd.size() != 1 || ((log_cmd.size() > 0) ? log_cmd[0] : 3'd7) !== 3'd3 || ((log_cyc.size() > 0) ? log_cyc[0] : -1) != s + 2) begin n_bad++; $display("FAIL rst_new_make: got n=%0d cmd=%0d cyc=%0d want n=1 cmd=3 cyc=%0d", log_cmd.size(), (log_cmd.size() > 0) ? log_cmd[0] : 3'd7, (log_cyc.size() > 0) ? log_cyc[0] : -1, s + 2); end
   endtask

   initial begin
      test_reset();
      test_tap_left();
      test_hold_right();
      test_priority_stall();
      test_lockout();
      test_typematic();
      test_reset_mid_repeat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
